// File: rtl/fft_pkg.sv
// Shared constants, bank state encoding and index bit reversal for the FFT reorder path.
package fft_pkg;

  localparam int LOG2N_DEF    = 6;
  localparam int DATA_W_DEF   = 32;
  localparam int BITREV_MAX_W = 12;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  // Reverse the low w bits of v; the upper bits of v must be zero.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] v,
                                                     input int unsigned w);
    logic [BITREV_MAX_W-1:0] r;
    r = {<<{v}};
    return r >> (BITREV_MAX_W - w);
  endfunction

endpackage

// File: rtl/fft_bitrev_bank.sv
// One N x DATA_W sample bank: synchronous write port, asynchronous read port.
module fft_bitrev_bank
  import fft_pkg::*;
#(
  parameter int LOG2N  = LOG2N_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [LOG2N-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [LOG2N-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [1 << LOG2N];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong bit-reversal reorder buffer: natural-order frames in, bit-reversed frames out.
// Optional framing check (in_last / err_frame) enabled by defining BITREV_LAST_CHECK_EN.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int LOG2N  = LOG2N_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [LOG2N-1:0]  out_index,
  output logic              out_last
`ifdef BITREV_LAST_CHECK_EN
  ,
  input  logic              in_last,
  output logic              err_frame
`endif
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST_POS = LOG2N'(N - 1);

  bank_state_t       state [2];
  logic              wr_bank;
  logic              rd_bank;
  logic [LOG2N-1:0]  wr_cnt;
  logic [LOG2N-1:0]  rd_cnt;
  logic              wr_fire;
  logic              rd_load;
  logic [1:0]        wr_en;
  logic [LOG2N-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data [2];

  logic              vld_p1;
  logic              last_p1;
  logic [LOG2N-1:0]  idx_p1;
  logic [DATA_W-1:0] data_p1;

  // The write bank can only be FULL when both banks hold complete frames.
  assign in_ready = (state[wr_bank] != BANK_FULL);
  assign wr_fire  = in_valid & in_ready;
  assign rd_load  = (state[rd_bank] == BANK_FULL) && (!vld_p1 || out_ready);
  assign wr_en    = wr_fire ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign rd_addr  = LOG2N'(bitrev(BITREV_MAX_W'(rd_cnt), LOG2N));

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_bitrev_bank #(
      .LOG2N  (LOG2N),
      .DATA_W (DATA_W)
    ) u_bank (
      .clk     (clk),
      .wr_en   (wr_en[b]),
      .wr_addr (wr_cnt),
      .wr_data (in_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data[b])
    );
  end

  // Writer and reader never target the same bank in one cycle, so both updates apply.
  always_ff @(posedge clk) begin
    if (rst) begin
      state[0] <= BANK_EMPTY;
      state[1] <= BANK_EMPTY;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_cnt == LAST_POS) begin
          state[wr_bank] <= BANK_FULL;
          wr_bank        <= ~wr_bank;
          wr_cnt         <= '0;
        end else begin
          state[wr_bank] <= BANK_FILLING;
          wr_cnt         <= wr_cnt + 1'b1;
        end
      end
      if (rd_load) begin
        if (rd_cnt == LAST_POS) begin
          state[rd_bank] <= BANK_EMPTY;
          rd_bank        <= ~rd_bank;
          rd_cnt         <= '0;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end

  // Stage p1: output register, held while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      idx_p1  <= '0;
      data_p1 <= '0;
    end else if (rd_load) begin
      vld_p1  <= 1'b1;
      last_p1 <= (rd_cnt == LAST_POS);
      idx_p1  <= rd_addr;
      data_p1 <= rd_data[rd_bank];
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_last  = last_p1;
  assign out_index = idx_p1;
  assign out_data  = data_p1;

`ifdef BITREV_LAST_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_frame <= 1'b0;
    end else if (wr_fire && (in_last != (wr_cnt == LAST_POS))) begin
      err_frame <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: LOG2N=3 and LOG2N=6 instances against a frame-level model.
module tb_fft_bitrev_reorder;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic iv3, ir3, ov3, ord3, ol3;
  logic [DW-1:0] id3, od3;
  logic [2:0] oi3;
  logic iv6, ir6, ov6, ord6, ol6;
  logic [DW-1:0] id6, od6;
  logic [5:0] oi6;
`ifdef BITREV_LAST_CHECK_EN
  logic il3, err3, il6, err6;
  int pos3;
  bit bad_last;
`endif

  fft_bitrev_reorder #(.LOG2N(3), .DATA_W(DW)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .in_data(id3),
    .out_valid(ov3), .out_ready(ord3), .out_data(od3), .out_index(oi3), .out_last(ol3)
`ifdef BITREV_LAST_CHECK_EN
    , .in_last(il3), .err_frame(err3)
`endif
  );

  fft_bitrev_reorder #(.LOG2N(6), .DATA_W(DW)) dut6 (
    .clk(clk), .rst(rst), .in_valid(iv6), .in_ready(ir6), .in_data(id6),
    .out_valid(ov6), .out_ready(ord6), .out_data(od6), .out_index(oi6), .out_last(ol6)
`ifdef BITREV_LAST_CHECK_EN
    , .in_last(il6), .err_frame(err6)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int brev(input int p, input int w);
    int r = 0;
    for (int i = 0; i < w; i++)
      if ((p >> i) & 1) r |= 1 << (w - 1 - i);
    return r;
  endfunction

  // Frame-level model: accepted samples by arrival count, outputs by consumed count.
  logic [31:0] samples [2][4096];
  int in_cnt [2], out_cnt [2];
  bit armed [2], prv_rst [2], p_load [2], p_ov [2], p_ordy [2];
  logic [31:0] p_od [2];
  logic [DW-1:0] cap3 [$];
  logic [DW-1:0] cap6 [$];

  task automatic check(input int d, input bit r, input bit iv, input bit ir, input logic [31:0] idt,
                       input bit ov, input bit ordy, input logic [31:0] od,
                       input logic [31:0] oi, input bit ol);
    int nn, lg, pos, fr, idx, full;
    string pfx;
    nn  = d ? 64 : 8;
    lg  = d ? 6 : 3;
    pfx = d ? "n64" : "n8";
    if (armed[d]) begin
      if (prv_rst[d]) begin
        cmp({pfx, "_rst_out_valid"}, 32'(ov), 0);
        cmp({pfx, "_rst_out_last"}, 32'(ol), 0);
        cmp({pfx, "_rst_out_index"}, oi, 0);
        cmp({pfx, "_rst_out_data"}, od, 0);
        cmp({pfx, "_rst_in_ready"}, 32'(ir), 1);
      end else begin
        cmp({pfx, "_out_valid"}, 32'(ov), 32'(p_load[d] || (p_ov[d] && !p_ordy[d])));
        full = in_cnt[d] / nn - (out_cnt[d] + int'(ov)) / nn;
        cmp({pfx, "_in_ready"}, 32'(ir), 32'(full < 2));
        if (ov) begin
          pos = out_cnt[d] % nn;
          fr  = out_cnt[d] / nn;
          idx = brev(pos, lg);
          cmp({pfx, "_out_index"}, oi, 32'(idx));
          cmp({pfx, "_out_last"}, 32'(ol), 32'(pos == nn - 1));
          cmp({pfx, "_out_data"}, od, samples[d][fr * nn + idx]);
          if (p_ov[d] && !p_ordy[d]) cmp({pfx, "_hold_data"}, od, p_od[d]);
        end
      end
    end
    if (r) begin
      armed[d] = 1'b1; prv_rst[d] = 1'b1; in_cnt[d] = 0; out_cnt[d] = 0;
      p_load[d] = 1'b0; p_ov[d] = 1'b0; p_ordy[d] = 1'b0;
      return;
    end
    if (!armed[d]) return;
    prv_rst[d] = 1'b0;
    p_load[d] = ((in_cnt[d] / nn) * nn > out_cnt[d] + int'(ov)) && (!ov || ordy);
    if (iv && ir) begin
      samples[d][in_cnt[d]] = idt;
      in_cnt[d]++;
    end
    if (ov && ordy) begin
      if (d == 0) cap3.push_back(DW'(od)); else cap6.push_back(DW'(od));
      out_cnt[d]++;
    end
    p_ov[d] = ov; p_ordy[d] = ordy; p_od[d] = od;
  endtask

  always @(negedge clk) begin
    check(0, rst, iv3, ir3, 32'(id3), ov3, ord3, 32'(od3), 32'(oi3), ol3);
    check(1, rst, iv6, ir6, 32'(id6), ov6, ord6, 32'(od6), 32'(oi6), ol6);
  end

  int rmode3 = 0;
  initial begin
    ord3 = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode3)
        0: ord3 = 1'b1;
        1: ord3 = 1'b0;
        default: ord3 = 1'($urandom_range(0, 1));
      endcase
    end
  end

  int dval3 = 0;
  task automatic send3(input int count, input bit rnd_valid, input bit rnd_data);
    int sent = 0;
    int guard = 0;
    bit acc;
    logic [DW-1:0] v;
    v = rnd_data ? DW'($urandom) : DW'(dval3);
    while (sent < count) begin
      iv3 = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      id3 = v;
`ifdef BITREV_LAST_CHECK_EN
      il3 = bad_last ? (pos3 == 6) : (pos3 == 7);
`endif
      @(negedge clk);
      acc = iv3 && ir3;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        dval3++;
        v = rnd_data ? DW'($urandom) : DW'(dval3);
`ifdef BITREV_LAST_CHECK_EN
        pos3 = (pos3 + 1) % 8;
`endif
      end
      guard++;
      if (guard > 5000) begin
        cmp("send3_timeout", 32'(sent), 32'(count));
        break;
      end
    end
    iv3 = 1'b0;
  endtask

  task automatic wait_cap(input int d, input int k);
    int g = 0;
    while (((d == 0) ? cap3.size() : cap6.size()) < k && g < 3000) begin
      @(posedge clk); #1;
      g++;
    end
    cmp(d ? "n64_drain_count" : "n8_drain_count",
        32'((d == 0) ? cap3.size() : cap6.size()), 32'(k));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef BITREV_LAST_CHECK_EN
    pos3 = 0;
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int exp8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  initial begin
    int dval6, drops;
    bit acc;
    rst = 1'b1; iv3 = 1'b0; id3 = '0; iv6 = 1'b0; id6 = '0; ord6 = 1'b1;
`ifdef BITREV_LAST_CHECK_EN
    il3 = 1'b0; il6 = 1'b0; pos3 = 0; bad_last = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cmp("reset_in_ready", 32'(ir3), 1);
    cmp("reset_out_valid", 32'(ov3), 0);

    // Single frame 0..7, first output exactly one edge after the last accept.
    cap3.delete(); dval3 = 0;
    send3(8, 1'b0, 1'b0);
    cmp("t1_valid_before", 32'(ov3), 0);
    @(posedge clk); #1;
    cmp("t1_valid_rise", 32'(ov3), 1);
    cmp("t1_first_data", 32'(od3), 0);
    wait_cap(0, 8);
    for (int i = 0; i < 8 && i < cap3.size(); i++) cmp($sformatf("t1_out%0d", i), 32'(cap3[i]), 32'(exp8[i]));

    // Four back-to-back N=64 frames at full rate.
    cap6.delete(); dval6 = 0; drops = 0;
    for (int c = 0; c < 600 && dval6 < 256; c++) begin
      iv6 = 1'b1; id6 = DW'(dval6);
`ifdef BITREV_LAST_CHECK_EN
      il6 = (dval6 % 64 == 63);
`endif
      @(negedge clk);
      acc = ir6;
      if (!ir6) drops++;
      @(posedge clk); #1;
      if (acc) dval6++;
    end
    iv6 = 1'b0;
    cmp("t2_in_ready_drops", 32'(drops), 0);
    cmp("t2_accepted", 32'(dval6), 256);
    wait_cap(1, 256);
    for (int f = 0; f < 4 && cap6.size() >= 256; f++) begin
      cmp($sformatf("t2_f%0d_pos1", f), 32'(cap6[f * 64 + 1]), 32'(f * 64 + 32));
      cmp($sformatf("t2_f%0d_pos63", f), 32'(cap6[f * 64 + 63]), 32'(f * 64 + 63));
    end
`ifdef BITREV_LAST_CHECK_EN
    cmp("t2_err_frame", 32'(err6), 0);
`endif

    // Backpressure: 16 samples with out_ready low fill both banks.
    rmode3 = 1;
    repeat (2) @(posedge clk);
    #1;
    cap3.delete(); dval3 = 0;
    send3(16, 1'b0, 1'b0);
    cmp("t3_in_ready_low", 32'(ir3), 0);
    cmp("t3_out_valid", 32'(ov3), 1);
    cmp("t3_hold0", 32'(od3), 0);
    repeat (5) @(posedge clk);
    #1;
    cmp("t3_hold5", 32'(od3), 0);
    cmp("t3_still_stalled", 32'(ir3), 0);
    rmode3 = 0;
    wait_cap(0, 16);
    for (int i = 0; i < 16 && i < cap3.size(); i++)
      cmp($sformatf("t3_out%0d", i), 32'(cap3[i]), 32'((i / 8) * 8 + exp8[i % 8]));
    cmp("t3_in_ready_back", 32'(ir3), 1);

    // Random valid/ready over 20 frames of random data.
    rmode3 = 2;
    cap3.delete();
    send3(160, 1'b1, 1'b1);
    wait_cap(0, 160);
    rmode3 = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset while frame 0 drains and frame 1 is half written.
    dval3 = 0;
    send3(8, 1'b0, 1'b0);
    send3(5, 1'b0, 1'b0);
    do_reset();
    cmp("t5_out_valid", 32'(ov3), 0);
    cmp("t5_in_ready", 32'(ir3), 1);
    repeat (3) @(posedge clk);
    #1;
    cmp("t5_no_stale_output", 32'(ov3), 0);
    cap3.delete(); dval3 = 0;
    send3(8, 1'b0, 1'b0);
    wait_cap(0, 8);
    for (int i = 0; i < 8 && i < cap3.size(); i++) cmp($sformatf("t5_out%0d", i), 32'(cap3[i]), 32'(exp8[i]));

`ifdef BITREV_LAST_CHECK_EN
    cmp("t6_err_clear", 32'(err3), 0);
    bad_last = 1'b1;
    cap3.delete(); dval3 = 100;
    send3(8, 1'b0, 1'b0);
    bad_last = 1'b0;
    cmp("t6_err_set", 32'(err3), 1);
    wait_cap(0, 8);
    for (int i = 0; i < 8 && i < cap3.size(); i++) cmp($sformatf("t6_out%0d", i), 32'(cap3[i]), 32'(100 + exp8[i]));
    cmp("t6_err_sticky", 32'(err3), 1);
    do_reset();
    cmp("t6_err_rst", 32'(err3), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
